// File: rtl/stopwatch_control.sv
// Stopwatch control: button synchronizers, run/lap/stop FSM and centisecond prescaler
// driving the tick/clear/hold controls of an external digit counter chain.
module stopwatch_control #(
  parameter int unsigned CLK_DIV = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       reset_lap,
  output logic       tick,
  output logic       clr,
  output logic       hold,
  output logic       running,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StLap  = 2'b10,
    StStop = 2'b11
  } state_e;

  localparam logic [19:0] TickAt = 20'(CLK_DIV - 1);

  // Button synchronizers plus history flop; history resets to 0 so a button held
  // through reset release still yields exactly one edge.
  logic [1:0] ss_sync_q, rl_sync_q;
  logic       ss_hist_q, rl_hist_q;
  logic       ss_edge, rl_edge;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_sync_q <= 2'b00;
      rl_sync_q <= 2'b00;
      ss_hist_q <= 1'b0;
      rl_hist_q <= 1'b0;
    end else begin
      ss_sync_q <= {ss_sync_q[0], start_stop};
      rl_sync_q <= {rl_sync_q[0], reset_lap};
      ss_hist_q <= ss_sync_q[1];
      rl_hist_q <= rl_sync_q[1];
    end
  end

  assign ss_edge = ss_sync_q[1] & ~ss_hist_q;
  assign rl_edge = rl_sync_q[1] & ~rl_hist_q;

  state_e      state_q, state_d;
  logic [19:0] presc_q, presc_d;
  logic        run_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
    end
  end

  // start_stop has priority; a simultaneous reset_lap edge is dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ss_edge) state_d = StRun;
      end
      StRun: begin
        if (ss_edge)      state_d = StStop;
        else if (rl_edge) state_d = StLap;
      end
      StLap: begin
        if (ss_edge)      state_d = StStop;
        else if (rl_edge) state_d = StRun;
      end
      StStop: begin
        if (ss_edge)      state_d = StRun;
        else if (rl_edge) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Counts on registered state, so the period in flight at a stop is held, not lost.
  always_comb begin
    presc_d = presc_q;
    if (state_d == StIdle) begin
      presc_d = '0;
    end else if (run_q) begin
      presc_d = (presc_q == TickAt) ? 20'd0 : presc_q + 20'd1;
    end
  end

  assign run_q   = (state_q == StRun) || (state_q == StLap);
  assign running = run_q;
  assign tick    = run_q && (presc_q == TickAt);
  assign clr     = (state_q == StIdle);
  assign hold    = (state_q == StLap);
  assign state   = state_q;

endmodule

// File: tb/tb_stopwatch_control.sv
// Randomized and directed bench for stopwatch_control against a table-driven
// reference model of the stopwatch behaviour (CLK_DIV = 4).
module tb_stopwatch_control;

  localparam int unsigned Div = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_stop = 1'b0;
  logic       reset_lap = 1'b0;
  logic       tick, clr, hold, running;
  logic [1:0] state;
  logic [5:0] outs;

  stopwatch_control #(.CLK_DIV(Div)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .reset_lap  (reset_lap),
    .tick       (tick),
    .clr        (clr),
    .hold       (hold),
    .running    (running),
    .state      (state)
  );

  always #5 clk = ~clk;

  assign outs = {state, tick, clr, hold, running};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // Reference model: 0=IDLE 1=RUN 2=LAP 3=STOP; transitions by lookup table.
  localparam int NextSs [4] = '{1, 3, 3, 1};
  localparam int NextRl [4] = '{0, 2, 1, 0};

  int m_state;
  int m_cnt;      // cycles spent running since last IDLE
  bit ss_h [3];   // sampled levels, [0] newest
  bit rl_h [3];

  function automatic void model_reset();
    m_state = 0;
    m_cnt   = 0;
    for (int i = 0; i < 3; i++) begin
      ss_h[i] = 1'b0;
      rl_h[i] = 1'b0;
    end
  endfunction

  // A level seen rising at edge n acts at edge n+2.
  function automatic void model_clock(input bit ss, input bit rl);
    bit ss_rise, rl_rise;
    ss_rise = ss_h[1] && !ss_h[2];
    rl_rise = rl_h[1] && !rl_h[2];
    if (m_state == 1 || m_state == 2) m_cnt++;
    if (ss_rise)      m_state = NextSs[m_state];
    else if (rl_rise) m_state = NextRl[m_state];
    if (m_state == 0) m_cnt = 0;
    ss_h[2] = ss_h[1]; ss_h[1] = ss_h[0]; ss_h[0] = ss;
    rl_h[2] = rl_h[1]; rl_h[1] = rl_h[0]; rl_h[0] = rl;
  endfunction

  function automatic logic [5:0] model_outs();
    bit run;
    run = (m_state == 1) || (m_state == 2);
    return {2'(m_state), run && ((m_cnt % Div) == Div - 1), m_state == 0, m_state == 2, run};
  endfunction

  task automatic cyc_r(input bit ss, input bit rl, input bit r);
    @(negedge clk);
    rst = r;
    start_stop = ss;
    reset_lap = rl;
    @(posedge clk);
    if (rst) model_clock(ss, rl);
    #1 check_eq("outs", 32'(outs), 32'(model_outs()));
  endtask

  task automatic cyc(input bit ss, input bit rl);
    cyc_r(ss, rl, 1'b1);
  endtask

  // Asynchronous assert mid-cycle, two clocks in reset, release with given levels.
  task automatic pulse_reset(input bit ss, input bit rl);
    #($urandom_range(1, 3));
    rst = 1'b0;
    #1 check_eq("rst_async", 32'(outs), 32'(6'b00_0_1_0_0));
    model_reset();
    cyc_r(ss, rl, 1'b0);
    cyc_r(ss, rl, 1'b0);
    cyc_r(ss, rl, 1'b1);
  endtask

  task automatic press(input bit ss, input bit rl);
    cyc(ss, rl);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  initial begin
    int cnt;
    logic [1:0] prev;
    bit ss_lvl, rl_lvl;

    model_reset();
    #1 rst = 1'b0;
    #1 check_eq("rst_state", 32'(outs), 32'(6'b00_0_1_0_0));
    cyc_r(1'b0, 1'b0, 1'b0);
    cyc_r(1'b0, 1'b0, 1'b1);

    // Start: no change one edge early, RUN on the third edge.
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check_eq("ss_early", 32'(state), 32'd0);
    cyc(1'b0, 1'b0);
    check_eq("ss_latency", 32'(state), 32'd1);
    check_eq("clr_fall", 32'(clr), 32'd0);
    check_eq("tick_entry", 32'(tick), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b0);
      check_eq($sformatf("tick_c%0d", i), 32'(tick), 32'((i % 4) == 3));
    end

    // Stop mid-period, hold, resume with the remaining partial period.
    press(1'b1, 1'b0);
    check_eq("stop_state", 32'(state), 32'd3);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0);
      if (tick) cnt++;
    end
    check_eq("stop_no_tick", 32'(cnt), 32'd0);
    press(1'b1, 1'b0);
    check_eq("resume_state", 32'(state), 32'd1);
    check_eq("resume_tick", 32'(tick), 32'd1);

    // Lap freeze and release.
    press(1'b0, 1'b1);
    check_eq("lap_state", 32'(state), 32'd2);
    check_eq("lap_hold", 32'(hold), 32'd1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0);
      if (tick) cnt++;
    end
    check_eq("lap_ticks", 32'(cnt), 32'd2);
    press(1'b0, 1'b1);
    check_eq("unlap_state", 32'(state), 32'd1);
    check_eq("unlap_hold", 32'(hold), 32'd0);

    // Simultaneous edges: start_stop wins.
    press(1'b1, 1'b1);
    check_eq("both_state", 32'(state), 32'd3);
    check_eq("both_hold", 32'(hold), 32'd0);

    // Reset from STOP, further reset_lap presses ignored in IDLE.
    press(1'b0, 1'b1);
    check_eq("idle_state", 32'(state), 32'd0);
    check_eq("idle_clr", 32'(clr), 32'd1);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check_eq("idle_stays", 32'(state), 32'd0);

    // Reset while tick is high; start_stop held across release.
    press(1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0);
    check_eq("tick_pre_rst", 32'(tick), 32'd1);
    pulse_reset(1'b1, 1'b0);
    prev = state;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b0);
      if (state != prev) cnt++;
      prev = state;
    end
    check_eq("held_one_edge", 32'(cnt), 32'd1);
    check_eq("held_run", 32'(state), 32'd1);

    // Random button activity with occasional resets.
    ss_lvl = 1'b0;
    rl_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) ss_lvl = ~ss_lvl;
      if ($urandom_range(0, 5) == 0) rl_lvl = ~rl_lvl;
      if ($urandom_range(0, 399) == 0) pulse_reset(ss_lvl, rl_lvl);
      else cyc(ss_lvl, rl_lvl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
